ldtu_hamm_tx: RTL and testbench
===============================

// Module: ldtu_hamm_tx
// PURPOSE
//  Hamming encoder feeding the LiTe-DTU output FIFO: 32-bit data word -> 38-bit SEC code word.
//  Bit layout matches the FIFO-side Hamming decoder, so decode(encode(d)) == d with HammError=0.
//  Sits between the data-formatter output and the FIFO write port.
//  Has a 1-deep registered output with valid/ready, a diagnostic single-bit error injector and an encoded-word counter.
// PARAMETERS
//  Nbits_32   32  data width (fixed; the bit map below assumes 32)
//  Nbits_ham  38  code-word width (fixed)
//  CntBits    16  width of word_count
// PORTS
//  CLK         in   1          LiTe-DTU clock
//  reset       in   1          async active-low reset (0 = LiTe-DTU inactive)
//  in_valid    in   1          data_in is valid this cycle
//  in_ready    out  1          encoder can accept data_in this cycle
//  data_in     in   Nbits_32   data word to encode
//  inject_en   in   1          flip one code-word bit of the word accepted this cycle
//  inject_pos  in   6          1-based position to flip (syndrome convention)
//  out_valid   out  1          data_ham_in holds a code word
//  out_ready   in   1          FIFO accepts data_ham_in this cycle
//  data_ham_in out  Nbits_ham  encoded word to FIFO
//  word_count  out  CntBits    number of words accepted since reset
// BEHAVIOUR
//  Reset (async, reset=0): out_valid=0, data_ham_in=0, word_count=0. in_ready=0 while reset=0.
//  in_ready = reset & (~out_valid | out_ready). This is combinational and allows a back-to-back pass-through.
//  Accept event: in_valid & in_ready.
//   On the next CLK edge, data_ham_in <= encode(data_in) XOR inject mask, out_valid <= 1, word_count += 1.
//   word_count wraps from 2^CntBits-1 to 0.
//  Pop event: out_valid & out_ready & ~accept. On the next edge, out_valid <= 0 and data_ham_in holds its value.
//  Accept and pop in the same cycle: the register is replaced and out_valid stays 1. There is no bubble.
//  While out_valid=1 and out_ready=0: data_ham_in and out_valid hold and in_ready=0. No data is lost or overwritten.
//  Latency: 1 cycle from accept to out_valid. Throughput: 1 word/cycle.
//  Encode map (code bit <- data bit):
//   ham[2]        <- d[0]
//   ham[6:4]      <- d[3:1]
//   ham[14:8]     <- d[10:4]
//   ham[30:16]    <- d[25:11]
//   ham[37:32]    <- d[31:26]
//  Parity bits: ham[2^k-1] for k=0..5, i.e. bits 0, 1, 3, 7, 15, 31.
//   Parity bit k = XOR of all data-carrying ham[i] with bit k of (i+1) set.
//   Result: XOR over the parity group, parity included, is 0 for every k.
//  Injection mask, applied only on an accept with inject_en=1:
//   inject_pos in 1..38 flips ham[inject_pos-1].
//   inject_pos 0 or 39..63 gives no flip.
//   inject_en is ignored when no accept occurs.
//  Reset asserted mid-transfer: the pending word is discarded and out_valid drops immediately (async).
//  Encode path: purely combinational from data_in into the output register. No other state.
// TESTING
//  1 data_in=32'h00000000, out_ready=1 -> data_ham_in=38'h0000000000 one cycle later, word_count=1.
//  2 data_in=32'h00000001 -> 38'h0000000007. data_in=32'hFFFFFFFF -> 38'h3F7FFFFFF4.
//  3 Stream 1000 random words with random out_ready through the decoder model.
//     -> outputs match inputs in order, HammError=0, word_count=1000, no drops or duplicates.
//  4 Hold out_ready=0 with in_valid=1 -> in_ready=0 after the first accept, data_ham_in stable.
//     Release -> the next word appears the cycle after release.
//  5 inject_en=1 with inject_pos=1..38 (and 0, 39, 63) on data 32'hA5A5A5A5.
//     -> decoder corrects the data and HammError=1 for 1..38.
//     -> code word unmodified and HammError=0 for 0/39/63.
//  6 Assert reset=0 while out_valid=1 and out_ready=0.
//     -> out_valid, data_ham_in and word_count go to 0 without a clock edge.
//     -> in_ready=0 until reset=1.

Source files
------------

// File: rtl/ldtu_hamm_tx.sv
// ldtu_hamm_tx: 32-bit to 38-bit SEC Hamming encoder with a 1-deep valid/ready output
// register, a diagnostic single-bit error injector and an accepted-word counter.
module ldtu_hamm_tx #(
  parameter int Nbits_32  = 32,
  parameter int Nbits_ham = 38,
  parameter int CntBits   = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Nbits_32-1:0]  data_in,
  input  logic                 inject_en,
  input  logic [5:0]           inject_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Nbits_ham-1:0] data_ham_in,
  output logic [CntBits-1:0]   word_count
);
  logic [Nbits_ham-1:0] d_map, ham_enc, inj_mask, ham_d, ham_q;
  logic                 valid_d, valid_q, accept, par;
  logic [CntBits-1:0]   cnt_d, cnt_q;

  assign in_ready    = reset & (~valid_q | out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = valid_q;
  assign data_ham_in = ham_q;
  assign word_count  = cnt_q;

  // Data occupies every non-power-of-two position; parity k covers positions with bit k of (i+1) set.
  always_comb begin
    d_map = '0;
    d_map[2]     = data_in[0];
    d_map[6:4]   = data_in[3:1];
    d_map[14:8]  = data_in[10:4];
    d_map[30:16] = data_in[25:11];
    d_map[37:32] = data_in[31:26];
    ham_enc = d_map;
    par = 1'b0;
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int i = 0; i < Nbits_ham; i++)
        if (((i + 1) & (1 << k)) != 0) par = par ^ d_map[i];
      ham_enc[(1 << k) - 1] = par;
    end
    inj_mask = (inject_en && inject_pos != 6'd0 && inject_pos <= 6'd38) ?
               (Nbits_ham'(1) << (inject_pos - 6'd1)) : '0;
  end

  always_comb begin
    ham_d   = accept ? (ham_enc ^ inj_mask) : ham_q;
    valid_d = accept | (valid_q & ~out_ready);
    cnt_d   = cnt_q + CntBits'(accept);
  end

  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      ham_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ham_q   <= ham_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_ldtu_hamm_tx.sv
// tb_ldtu_hamm_tx: table-driven and randomized checks of ldtu_hamm_tx against a
// syndrome-based Hamming encode/decode model.
module tb_ldtu_hamm_tx;
  logic        CLK = 1'b0;
  logic        reset, in_valid, in_ready, inject_en, out_valid, out_ready;
  logic [31:0] data_in;
  logic [5:0]  inject_pos;
  logic [37:0] data_ham_in;
  logic [15:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;

  ldtu_hamm_tx dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .inject_en(inject_en), .inject_pos(inject_pos),
    .out_valid(out_valid), .out_ready(out_ready), .data_ham_in(data_ham_in),
    .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [5:0]  pos;
    logic [37:0] exp_ham;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // Data fills positions 1..38 that are not powers of two; parity bits are the
  // bits of the XOR of the positions of all set data bits.
  function automatic logic [37:0] enc_m(input logic [31:0] d);
    logic [37:0] h = '0;
    int j = 0;
    int s = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        h[p-1] = d[j];
        j++;
      end
    for (int p = 1; p <= 38; p++) if (h[p-1]) s = s ^ p;
    for (int k = 0; k < 6; k++) h[(1 << k) - 1] = s[k];
    return h;
  endfunction

  function automatic void dec_m(input logic [37:0] h_in, output logic [31:0] d, output logic err);
    logic [37:0] h = h_in;
    int s = 0;
    int j = 0;
    for (int p = 1; p <= 38; p++) if (h[p-1]) s = s ^ p;
    err = (s != 0);
    if (s >= 1 && s <= 38) h[s-1] = ~h[s-1];
    d = '0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = h[p-1];
        j++;
      end
  endfunction

  function automatic logic [37:0] mask_m(input int pos);
    logic [37:0] m = '0;
    if (pos >= 1 && pos <= 38) m[pos-1] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] dd;
    logic        ee, rdy;
    logic [37:0] held;
    int          exp_cnt, acc, cyc;
    int          plist[$];

    vecs.push_back('{32'h00000000, 1'b0, 6'd0, 38'h0000000000, 1'b0});
    vecs.push_back('{32'h00000001, 1'b0, 6'd0, 38'h0000000007, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 1'b0, 6'd0, 38'h3F7FFFFFF4, 1'b0});
    for (int p = 1; p <= 38; p++) plist.push_back(p);
    plist.push_back(0);
    plist.push_back(39);
    plist.push_back(63);
    foreach (plist[i])
      vecs.push_back('{32'hA5A5A5A5, 1'b1, 6'(plist[i]),
                       enc_m(32'hA5A5A5A5) ^ mask_m(plist[i]),
                       (plist[i] >= 1 && plist[i] <= 38)});

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    inject_en = 1'b0; inject_pos = '0;
    repeat (2) @(negedge CLK);
    in_valid = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ham", 64'(data_ham_in), 0);
    chk("rst_cnt", 64'(word_count), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    in_valid = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    exp_cnt = 0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      data_in = vecs[i].data; inject_en = vecs[i].en; inject_pos = vecs[i].pos;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0; inject_en = 1'b0;
      exp_cnt++;
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("tbl%0d_ham", i), 64'(data_ham_in), 64'(vecs[i].exp_ham));
      dec_m(data_ham_in, dd, ee);
      chk($sformatf("tbl%0d_dec", i), 64'(dd), 64'(vecs[i].data));
      chk($sformatf("tbl%0d_err", i), 64'(ee), 64'(vecs[i].exp_err));
      chk($sformatf("tbl%0d_cnt", i), 64'(word_count), 64'(exp_cnt));
    end

    @(negedge CLK);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    exp_cnt = 0;
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge CLK);
      cyc++;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      data_in   = $urandom;
      #1;
      rdy = (q.size() == 0) || out_ready;
      chk("str_in_ready", 64'(in_ready), 64'(rdy));
      chk("str_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && out_ready) begin
        dec_m(data_ham_in, dd, ee);
        chk("str_data", 64'(dd), 64'(q[0]));
        chk("str_err", 64'(ee), 0);
        void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        q.push_back(data_in);
        acc++;
        exp_cnt++;
      end
    end
    chk("str_accepted", 64'(acc), 1000);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (q.size() != 0) begin
      dec_m(data_ham_in, dd, ee);
      chk("drain_data", 64'(dd), 64'(q[0]));
      void'(q.pop_front());
    end
    @(negedge CLK);
    chk("drain_valid", 64'(out_valid), 0);
    chk("str_cnt", 64'(word_count), 1000);

    in_valid = 1'b1; out_ready = 1'b0; data_in = 32'h12345678;
    @(posedge CLK);
    #1;
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_ham", 64'(data_ham_in), 64'(enc_m(32'h12345678)));
    held = data_ham_in;
    data_in = 32'hCAFEF00D; inject_en = 1'b1; inject_pos = 6'd1;
    repeat (4) begin
      @(negedge CLK);
      chk("bp_hold", 64'(data_ham_in), 64'(enc_m(32'h12345678)));
      chk("bp_in_ready_hold", 64'(in_ready), 0);
    end
    chk("bp_cnt", 64'(word_count), 1001);
    inject_en = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    chk("bp_next_ham", 64'(data_ham_in), 64'(enc_m(32'hCAFEF00D)));
    chk("bp_next_valid", 64'(out_valid), 1);
    chk("bp_next_cnt", 64'(word_count), 1002);
    chk("bp_changed", 64'(data_ham_in != held), 1);

    @(negedge CLK);
    in_valid = 1'b1; out_ready = 1'b0; data_in = 32'hDEADBEEF;
    @(posedge CLK);
    #1;
    chk("ar_pre_valid", 64'(out_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 0);
    chk("ar_ham", 64'(data_ham_in), 0);
    chk("ar_cnt", 64'(word_count), 0);
    chk("ar_in_ready", 64'(in_ready), 0);
    repeat (3) @(negedge CLK);
    chk("ar_hold_valid", 64'(out_valid), 0);
    chk("ar_hold_cnt", 64'(word_count), 0);
    chk("ar_hold_in_ready", 64'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk("ar_release_in_ready", 64'(in_ready), 1);
    in_valid = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
